hilo_muldiv: RTL and testbench



---
 rtl/hilo_muldiv_pkg.sv | 28 ++
 rtl/hilo_muldiv_if.sv | 27 ++
 rtl/hilo_muldiv_div_radix2.sv | 41 ++++
 rtl/hilo_muldiv.sv | 158 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared op/state encodings and helpers for the HI/LO multiply/divide unit.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
package hilo_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

  localparam int MD_ITER = 32;

  function automatic logic [31:0] neg_if(
    input logic        n,
    input logic [31:0] v
  );
    return n ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// master = EX stage issuing ops, slave = the unit.
interface hilo_muldiv_if;

  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        stall;
  logic        done;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start, op, src1, src2, cancel,
    input  stall, done, hi_we, lo_we, hi_o, lo_o
  );

  modport slave (
    input  start, op, src1, src2, cancel,
    output stall, done, hi_we, lo_we, hi_o, lo_o
  );

endinterface

// File: rtl/hilo_muldiv_div_radix2.sv
// Restoring radix-2 divider datapath on unsigned magnitudes.
// One quotient bit per enabled cycle; exposes the next-step values.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] rem_nxt,
  output logic [31:0] quo_nxt
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [32:0] trial;
  logic        fits;

  // remainder < divisor, so the shifted-in value always fits 33 bits
  assign trial   = {rem_q, quo_q[31]} - {1'b0, dvs_q};
  assign fits    = ~trial[32];
  assign rem_nxt = fits ? trial[31:0] : {rem_q[30:0], quo_q[31]};
  assign quo_nxt = {quo_q[30:0], fits};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (en) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO; stalls EX while busy.
// MULDIV_FAST_MUL_EN: multiply in the start cycle instead of 32 steps.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave md
);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q;
  logic        neg_lo_q, neg_hi_q;
  logic [63:0] acc_q;
  logic [31:0] mcd_q;
  logic [31:0] res_hi_q, res_lo_q;
  logic [31:0] hi_q, lo_q;

  md_op_e      op;
  logic        is_div, sgn, s1_neg, s2_neg;
  logic        accept, last, div_zero;
  logic [31:0] s1_mag, s2_mag;
  logic [31:0] rem_nxt, quo_nxt;
  logic [32:0] sum;
  logic [63:0] acc_nxt, mul_res;

  assign op       = md_op_e'(md.op);
  assign is_div   = (op == MD_DIV) || (op == MD_DIVU);
  assign sgn      = (op == MD_MULT) || (op == MD_DIV);
  assign s1_neg   = sgn & md.src1[31];
  assign s2_neg   = sgn & md.src2[31];
  assign s1_mag   = neg_if(s1_neg, md.src1);
  assign s2_mag   = neg_if(s2_neg, md.src2);
  assign div_zero = (md.src2 == '0);
  assign accept   = (state_q == S_IDLE) & md.start & ~md.cancel;
  assign last     = (cnt_q == 6'(MD_ITER - 1));

  // shift-add: multiplier sits in acc[31:0], product grows from the top
  assign sum     = {1'b0, acc_q[63:32]}
                 + (acc_q[0] ? {1'b0, mcd_q} : 33'd0);
  assign acc_nxt = {sum, acc_q[31:1]};
  assign mul_res = neg_lo_q ? -acc_nxt : acc_nxt;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_p;
  // sign-extended operands give the signed product in the low 64 bits
  assign fast_p = {{32{s1_neg}}, md.src1} * {{32{s2_neg}}, md.src2};
`endif

  div_radix2 u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept & is_div),
    .en       (state_q == S_DIV),
    .dividend (s1_mag),
    .divisor  (s2_mag),
    .rem_nxt  (rem_nxt),
    .quo_nxt  (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (md.cancel) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (md.start) begin
            if (is_div)
              state_d = div_zero ? S_DONE : S_DIV;
            else
`ifdef MULDIV_FAST_MUL_EN
              state_d = S_DONE;
`else
              state_d = S_MUL;
`endif
          end
        end
        S_MUL:   if (last) state_d = S_DONE;
        S_DIV:   if (last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    md.stall = accept
             | (state_q == S_MUL)
             | (state_q == S_DIV);
    md.done  = (state_q == S_DONE) & ~md.cancel;
    md.hi_we = md.done;
    md.lo_we = md.done;
    // forward the staged result in the write cycle
    md.hi_o  = md.done ? res_hi_q : hi_q;
    md.lo_o  = md.done ? res_lo_q : lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      mcd_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            neg_lo_q <= s1_neg ^ s2_neg;
            neg_hi_q <= s1_neg;
            acc_q    <= {32'b0, s2_mag};
            mcd_q    <= s1_mag;
            if (is_div && div_zero) begin
              res_hi_q <= md.src1;
              res_lo_q <= '1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              {res_hi_q, res_lo_q} <= fast_p;
            end
`endif
          end
        end
        S_MUL: begin
          cnt_q <= cnt_q + 6'd1;
          acc_q <= acc_nxt;
          if (last) {res_hi_q, res_lo_q} <= mul_res;
        end
        S_DIV: begin
          cnt_q <= cnt_q + 6'd1;
          if (last) begin
            res_hi_q <= neg_if(neg_hi_q, rem_nxt);
            res_lo_q <= neg_if(neg_lo_q, quo_nxt);
          end
        end
        S_DONE: begin
          if (md.done) begin
            hi_q <= res_hi_q;
            lo_q <= res_lo_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: reference arithmetic model,
// latency/stall checks, cancel, reset and held-start cases.
module tb_hilo_muldiv;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_if md();

  hilo_muldiv dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sbq[$];
  int          nerr  = 0;
  int          nchk  = 0;
  int          ndone = 0;
  int          nacc  = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        q = sa * sb;
        p = q;
      end
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic int lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1]) return (b == 0) ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && md.done) begin
      ndone++;
      if (sbq.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("hi", md.hi_o, e.hi);
        check("lo", md.lo_o, e.lo);
        check("done_cycle", cyc, e.cyc);
        check("we", {md.hi_we, md.lo_we}, 2'b11);
        check("stall_in_done", md.stall, 0);
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  // call at a negedge with the unit idle; cycle 0 is the current cycle
  task automatic run(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input bit hold);
    exp_t        e;
    logic [63:0] r;
    int          l, sc, c0;
    bit          got;
    r  = model(op, a, b);
    l  = lat(op, b);
    c0 = cyc;
    md.start = 1'b1;
    md.op    = op;
    md.src1  = a;
    md.src2  = b;
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.cyc = c0 + l;
    sbq.push_back(e);
    nacc++;
    #1 sc = md.stall ? 1 : 0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (!hold) md.start = 1'b0;
      #1;
      if (md.stall) sc++;
      #1;
      if (sbq.size() == 0) got = 1;
    end
    md.start = 1'b0;
    if (!got) begin
      check("timeout", 0, 1);
      sbq.delete();
    end
    check("stall_cycles", sc, l);
    @(negedge clk);
    #1;
    check("hold_hi", md.hi_o, last_hi);
    check("hold_lo", md.lo_o, last_lo);
  endtask

  initial begin
    int c0;
    md.start  = 1'b0;
    md.op     = 2'b00;
    md.src1   = '0;
    md.src2   = '0;
    md.cancel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out", {md.hi_o, md.lo_o}, 64'd0);
    check("rst_ctl", {md.done, md.hi_we, md.lo_we, md.stall}, 4'd0);
    rst = 1'b0;

    @(negedge clk) run(2'b00, 32'hFFFF_FFFF, 32'd2, 0);
    @(negedge clk) run(2'b01, 32'hFFFF_FFFF, 32'd2, 0);
    @(negedge clk) run(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    @(negedge clk) run(2'b11, 32'd100, 32'd7, 0);
    @(negedge clk) run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    @(negedge clk) run(2'b11, 32'd5, 32'd0, 0);
    @(negedge clk) run(2'b10, 32'hFFFF_FFFB, 32'd0, 0);
    @(negedge clk) run(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run(2'($urandom_range(3)), $urandom, $urandom, 0);
    end

    // cancel in cycle 10 of a DIV, new op accepted in cycle 11
    @(negedge clk);
    c0 = cyc;
    md.start = 1'b1;
    md.op    = 2'b10;
    md.src1  = 32'd12345;
    md.src2  = 32'd17;
    @(negedge clk) md.start = 1'b0;
    while (cyc != c0 + 10) @(negedge clk);
    md.cancel = 1'b1;
    @(negedge clk);
    md.cancel = 1'b0;
    #1;
    check("cancel_idle", md.stall, 0);
    check("cancel_hi", md.hi_o, last_hi);
    check("cancel_lo", md.lo_o, last_lo);
    run(2'b11, 32'd1000, 32'd33, 0);

    // start together with cancel in IDLE is dropped
    @(negedge clk);
    md.start  = 1'b1;
    md.cancel = 1'b1;
    md.op     = 2'b01;
    #1 check("start_cancel_stall", md.stall, 0);
    @(negedge clk);
    md.start  = 1'b0;
    md.cancel = 1'b0;
    #1 check("start_cancel_idle", md.stall, 0);
    repeat (40) @(negedge clk);
    check("start_cancel_count", ndone, nacc);

    // start held high through the busy period
    @(negedge clk) run(2'b11, 32'd100, 32'd7, 1);
    repeat (40) @(negedge clk);
    check("held_start_count", ndone, nacc);

    // reset in cycle 20 of a DIV
    @(negedge clk);
    c0 = cyc;
    md.start = 1'b1;
    md.op    = 2'b10;
    md.src1  = 32'd999;
    md.src2  = 32'd3;
    @(negedge clk) md.start = 1'b0;
    while (cyc != c0 + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_out", {md.hi_o, md.lo_o}, 64'd0);
    check("rst_mid_ctl", {md.done, md.hi_we, md.lo_we, md.stall}, 4'd0);
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clk);
    check("final_done_count", ndone, nacc);

    @(negedge clk) run(2'b01, 32'd12, 32'd13, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
